// File: rtl/axi4_lite_sram_model.sv
// rtl/axi4_lite_sram_model.sv - AXI4-Lite slave SRAM with console/pass MMIO, read queue and optional backpressure
//
// Ports:
//   clk, reset                  clock (rising edge) and asynchronous active-high reset
//   mem_axi_aw*                 write address channel (awprot ignored)
//   mem_axi_w*                  write data channel with byte strobes
//   mem_axi_b*                  write response (00 OKAY, 10 SLVERR)
//   mem_axi_ar*                 read address channel (arprot ignored)
//   mem_axi_r*                  read data channel
//   console_valid/console_data  one-cycle pulse carrying the byte written to CONSOLE_ADDR
//   tests_passed                sticky flag set by writing PASS_VALUE to PASS_ADDR
module axi4_lite_sram_model #(
    parameter int          DATA_WIDTH   = 32,
    parameter int          MEM_BYTES    = 131072,
    parameter int          RD_DEPTH     = 4,
    parameter bit          STALL_EN     = 1'b0,
    parameter logic [63:0] STALL_SEED   = 64'd88172645463325252,
    parameter logic [31:0] CONSOLE_ADDR = 32'h1000_0000,
    parameter logic [31:0] PASS_ADDR    = 32'h2000_0000,
    parameter logic [31:0] PASS_VALUE   = 32'd123456789
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    mem_axi_awvalid,
    output logic                    mem_axi_awready,
    input  logic [31:0]             mem_axi_awaddr,
    input  logic [2:0]              mem_axi_awprot,
    input  logic                    mem_axi_wvalid,
    output logic                    mem_axi_wready,
    input  logic [DATA_WIDTH-1:0]   mem_axi_wdata,
    input  logic [DATA_WIDTH/8-1:0] mem_axi_wstrb,
    output logic                    mem_axi_bvalid,
    input  logic                    mem_axi_bready,
    output logic [1:0]              mem_axi_bresp,
    input  logic                    mem_axi_arvalid,
    output logic                    mem_axi_arready,
    input  logic [31:0]             mem_axi_araddr,
    input  logic [2:0]              mem_axi_arprot,
    output logic                    mem_axi_rvalid,
    input  logic                    mem_axi_rready,
    output logic [DATA_WIDTH-1:0]   mem_axi_rdata,
    output logic [1:0]              mem_axi_rresp,
    output logic                    console_valid,
    output logic [7:0]              console_data,
    output logic                    tests_passed
);
    localparam int WB        = DATA_WIDTH / 8;
    localparam int WB_LOG    = $clog2(WB);
    localparam int MEM_WORDS = MEM_BYTES / WB;
    localparam int IW        = (MEM_WORDS > 1) ? $clog2(MEM_WORDS) : 1;
    localparam int PW        = (RD_DEPTH > 1) ? $clog2(RD_DEPTH) : 1;
    localparam int CW        = $clog2(RD_DEPTH + 1);

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    logic unused_prot;
    assign unused_prot = ^{mem_axi_awprot, mem_axi_arprot};

    logic [DATA_WIDTH-1:0] mem [MEM_WORDS];

    // xorshift64 backpressure source; stall bits: 0 ar, 1 aw, 2 w, 3 r-pop, 4 b-commit
    logic [63:0] lfsr;
    logic [63:0] lfsr_next;
    logic [4:0]  stall;

    always_comb begin
        lfsr_next = lfsr ^ (lfsr << 13);
        lfsr_next = lfsr_next ^ (lfsr_next >> 7);
        lfsr_next = lfsr_next ^ (lfsr_next << 17);
    end

    assign stall = STALL_EN ? lfsr[4:0] : 5'd0;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) lfsr <= STALL_SEED;
        else       lfsr <= lfsr_next;
    end

    // Write path: independent AW and W holding registers
    logic                    aw_held, w_held;
    logic [31:0]             aw_addr;
    logic [DATA_WIDTH-1:0]   w_data;
    logic [DATA_WIDTH/8-1:0] w_strb;
    logic                    aw_fire, w_fire, commit;
    logic                    wr_in_range, wr_console, wr_pass;
    logic [IW-1:0]           wr_idx;
    logic [31:0]             sel_word;

    assign mem_axi_awready = !reset && !aw_held && !stall[1];
    assign mem_axi_wready  = !reset && !w_held && !stall[2];
    assign aw_fire = mem_axi_awvalid && mem_axi_awready;
    assign w_fire  = mem_axi_wvalid && mem_axi_wready;
    assign commit  = aw_held && w_held && (!mem_axi_bvalid || mem_axi_bready) && !stall[4];

    assign wr_in_range = 64'(aw_addr) < 64'(MEM_BYTES);
    assign wr_console  = aw_addr == CONSOLE_ADDR;
    assign wr_pass     = aw_addr == PASS_ADDR;
    assign wr_idx      = aw_addr[WB_LOG +: IW];

    // MMIO always looks at one 32-bit half; on a 64-bit bus addr[2] picks the upper half
    always_comb begin
        sel_word = w_data[31:0];
        if (DATA_WIDTH == 64 && aw_addr[2]) sel_word = w_data[DATA_WIDTH-1 -: 32];
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            aw_held        <= 1'b0;
            aw_addr        <= '0;
            w_held         <= 1'b0;
            w_data         <= '0;
            w_strb         <= '0;
            mem_axi_bvalid <= 1'b0;
            mem_axi_bresp  <= RESP_OKAY;
            console_valid  <= 1'b0;
            console_data   <= '0;
            tests_passed   <= 1'b0;
        end else begin
            console_valid <= 1'b0;
            if (aw_fire) begin
                aw_held <= 1'b1;
                aw_addr <= mem_axi_awaddr;
            end else if (commit) begin
                aw_held <= 1'b0;
            end
            if (w_fire) begin
                w_held <= 1'b1;
                w_data <= mem_axi_wdata;
                w_strb <= mem_axi_wstrb;
            end else if (commit) begin
                w_held <= 1'b0;
            end
            if (commit) begin
                mem_axi_bvalid <= 1'b1;
                mem_axi_bresp  <= RESP_OKAY;
                if (wr_in_range) begin
                    mem_axi_bresp <= RESP_OKAY;
                end else if (wr_console) begin
                    console_valid <= 1'b1;
                    console_data  <= sel_word[7:0];
                end else if (wr_pass) begin
                    if (sel_word == PASS_VALUE) tests_passed <= 1'b1;
                end else begin
                    mem_axi_bresp <= RESP_SLVERR;
                end
            end else if (mem_axi_bready) begin
                mem_axi_bvalid <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (commit && wr_in_range) begin
            for (int b = 0; b < WB; b++) begin
                if (w_strb[b]) mem[wr_idx][b*8 +: 8] <= w_data[b*8 +: 8];
            end
        end
    end

    // Read path: address queue feeding a single output register.
    // The beat sitting in the output register still counts against RD_DEPTH,
    // so a retiring beat (rvalid && rready) is what frees a slot when full.
    logic [31:0]   fifo [RD_DEPTH];
    logic [PW-1:0] wr_ptr, rd_ptr;
    logic [CW-1:0] fifo_cnt;
    logic [CW:0]   outstanding;
    logic          push, pop;
    logic [31:0]   rd_addr;
    logic          rd_in_range, rd_mmio;
    logic [IW-1:0] rd_idx;

    assign outstanding     = (CW+1)'(fifo_cnt) + (CW+1)'(mem_axi_rvalid);
    assign mem_axi_arready = !reset && !stall[0] &&
                             ((outstanding < (CW+1)'(RD_DEPTH)) || (mem_axi_rvalid && mem_axi_rready));
    assign push = mem_axi_arvalid && mem_axi_arready;
    assign pop  = (fifo_cnt != '0) && (!mem_axi_rvalid || mem_axi_rready) && !stall[3];

    assign rd_addr     = fifo[rd_ptr];
    assign rd_in_range = 64'(rd_addr) < 64'(MEM_BYTES);
    assign rd_mmio     = (rd_addr == CONSOLE_ADDR) || (rd_addr == PASS_ADDR);
    assign rd_idx      = rd_addr[WB_LOG +: IW];

    always_ff @(posedge clk) begin
        if (push) fifo[wr_ptr] <= mem_axi_araddr;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr         <= '0;
            rd_ptr         <= '0;
            fifo_cnt       <= '0;
            mem_axi_rvalid <= 1'b0;
            mem_axi_rdata  <= '0;
            mem_axi_rresp  <= RESP_OKAY;
        end else begin
            if (push) wr_ptr <= (wr_ptr == PW'(RD_DEPTH - 1)) ? '0 : wr_ptr + 1'b1;
            if (pop)  rd_ptr <= (rd_ptr == PW'(RD_DEPTH - 1)) ? '0 : rd_ptr + 1'b1;
            fifo_cnt <= fifo_cnt + CW'(push) - CW'(pop);
            if (pop) begin
                mem_axi_rvalid <= 1'b1;
                if (rd_in_range) begin
                    mem_axi_rdata <= mem[rd_idx];
                    mem_axi_rresp <= RESP_OKAY;
                end else begin
                    mem_axi_rdata <= '0;
                    mem_axi_rresp <= rd_mmio ? RESP_OKAY : RESP_SLVERR;
                end
            end else if (mem_axi_rready) begin
                mem_axi_rvalid <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_axi4_lite_sram_model.sv
// tb/tb_axi4_lite_sram_model.sv - bench for axi4_lite_sram_model: 32-bit plain and 64-bit stalled instances
module tb_axi4_lite_sram_model;
    localparam logic [31:0] CONSOLE = 32'h1000_0000;
    localparam logic [31:0] PASSA   = 32'h2000_0000;
    localparam logic [31:0] PASSV   = 32'd123456789;
    localparam int          MEMB    = 131072;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    logic [1:0]  awvalid, wvalid, bready, arvalid, rready;
    logic [31:0] awaddr, araddr;
    logic [63:0] wdata;
    logic [7:0]  wstrb;

    logic        awready0, wready0, bvalid0, arready0, rvalid0, cv0, tp0;
    logic        awready1, wready1, bvalid1, arready1, rvalid1, cv1, tp1;
    logic [1:0]  bresp0, rresp0, bresp1, rresp1;
    logic [31:0] rdata0;
    logic [63:0] rdata1;
    logic [7:0]  cd0, cd1;

    logic [1:0]  awready_v, wready_v, bvalid_v, arready_v, rvalid_v, cv_v, tp_v;
    logic [63:0] rdata_v [2];
    logic [1:0]  bresp_v [2];
    logic [1:0]  rresp_v [2];
    logic [7:0]  cd_v [2];
    assign awready_v = {awready1, awready0};
    assign wready_v  = {wready1, wready0};
    assign bvalid_v  = {bvalid1, bvalid0};
    assign arready_v = {arready1, arready0};
    assign rvalid_v  = {rvalid1, rvalid0};
    assign cv_v      = {cv1, cv0};
    assign tp_v      = {tp1, tp0};
    assign rdata_v[0] = {32'h0, rdata0};
    assign rdata_v[1] = rdata1;
    assign bresp_v[0] = bresp0;
    assign bresp_v[1] = bresp1;
    assign rresp_v[0] = rresp0;
    assign rresp_v[1] = rresp1;
    assign cd_v[0] = cd0;
    assign cd_v[1] = cd1;

    axi4_lite_sram_model #(.DATA_WIDTH(32), .STALL_EN(1'b0)) dut0 (
        .clk(clk), .reset(reset),
        .mem_axi_awvalid(awvalid[0]), .mem_axi_awready(awready0), .mem_axi_awaddr(awaddr), .mem_axi_awprot(3'b000),
        .mem_axi_wvalid(wvalid[0]), .mem_axi_wready(wready0), .mem_axi_wdata(wdata[31:0]), .mem_axi_wstrb(wstrb[3:0]),
        .mem_axi_bvalid(bvalid0), .mem_axi_bready(bready[0]), .mem_axi_bresp(bresp0),
        .mem_axi_arvalid(arvalid[0]), .mem_axi_arready(arready0), .mem_axi_araddr(araddr), .mem_axi_arprot(3'b000),
        .mem_axi_rvalid(rvalid0), .mem_axi_rready(rready[0]), .mem_axi_rdata(rdata0), .mem_axi_rresp(rresp0),
        .console_valid(cv0), .console_data(cd0), .tests_passed(tp0));

    axi4_lite_sram_model #(.DATA_WIDTH(64), .STALL_EN(1'b1)) dut1 (
        .clk(clk), .reset(reset),
        .mem_axi_awvalid(awvalid[1]), .mem_axi_awready(awready1), .mem_axi_awaddr(awaddr), .mem_axi_awprot(3'b000),
        .mem_axi_wvalid(wvalid[1]), .mem_axi_wready(wready1), .mem_axi_wdata(wdata), .mem_axi_wstrb(wstrb),
        .mem_axi_bvalid(bvalid1), .mem_axi_bready(bready[1]), .mem_axi_bresp(bresp1),
        .mem_axi_arvalid(arvalid[1]), .mem_axi_arready(arready1), .mem_axi_araddr(araddr), .mem_axi_arprot(3'b000),
        .mem_axi_rvalid(rvalid1), .mem_axi_rready(rready[1]), .mem_axi_rdata(rdata1), .mem_axi_rresp(rresp1),
        .console_valid(cv1), .console_data(cd1), .tests_passed(tp1));

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: actual %h required %h", name, act, exp);
        end
    endtask

    task automatic fail(input string name);
        n_cmp++;
        n_bad++;
        $display("FAIL %s: actual event/timeout required none", name);
    endtask

    // Behavioural model: byte-addressed memory per instance plus expectation queues
    typedef struct { int d; logic [1:0] resp; bit pass; } b_exp_t;
    typedef struct { int d; logic [63:0] data; logic [1:0] resp; } r_exp_t;
    typedef struct { int d; logic [7:0] v; } c_exp_t;

    logic [7:0] mem_m [longint];
    b_exp_t exp_b [$];
    r_exp_t exp_r [$];
    c_exp_t exp_c [$];
    bit     model_pass [2];

    int          b_cnt [2], r_cnt [2], cons_count [2];
    logic [63:0] last_rdata [2];
    logic [1:0]  last_rresp [2], last_bresp [2];
    logic [7:0]  last_cons [2];
    bit          r_hold [2];
    logic [63:0] r_prev [2];

    function automatic longint mkey(int d, logic [31:0] a);
        return (longint'(d) << 32) | longint'({32'h0, a});
    endfunction

    function automatic logic [63:0] model_word(int d, logic [31:0] a);
        logic [63:0] v = '0;
        int wb = d ? 8 : 4;
        logic [31:0] base = a & ~32'(wb - 1);
        for (int b = 0; b < wb; b++)
            if (mem_m.exists(mkey(d, base + 32'(b)))) v[b*8 +: 8] = mem_m[mkey(d, base + 32'(b))];
        return v;
    endfunction

    function automatic b_exp_t model_write(int d, logic [31:0] a, logic [63:0] dat, logic [7:0] st);
        b_exp_t e;
        c_exp_t c;
        int wb = d ? 8 : 4;
        logic [31:0] base = a & ~32'(wb - 1);
        logic [31:0] w32 = (d == 1 && a[2]) ? dat[63:32] : dat[31:0];
        e.d = d; e.resp = 2'b00; e.pass = 1'b0;
        if (a < MEMB) begin
            for (int b = 0; b < wb; b++)
                if (st[b]) mem_m[mkey(d, base + 32'(b))] = dat[b*8 +: 8];
        end else if (a == CONSOLE) begin
            c.d = d; c.v = w32[7:0];
            exp_c.push_back(c);
        end else if (a == PASSA) begin
            e.pass = (w32 == PASSV);
        end else begin
            e.resp = 2'b10;
        end
        return e;
    endfunction

    function automatic r_exp_t model_read(int d, logic [31:0] a);
        r_exp_t e;
        e.d = d; e.data = '0; e.resp = 2'b00;
        if (a < MEMB) e.data = model_word(d, a);
        else if (a != CONSOLE && a != PASSA) e.resp = 2'b10;
        return e;
    endfunction

    // Compare process: every cycle, checks each instance against the model
    b_exp_t be;
    r_exp_t re;
    c_exp_t ce;
    always @(negedge clk) begin
        if (reset) begin
            r_hold[0] = 1'b0;
            r_hold[1] = 1'b0;
        end else begin
            for (int d = 0; d < 2; d++) begin
                if (bvalid_v[d] && bready[d]) begin
                    b_cnt[d]++;
                    last_bresp[d] = bresp_v[d];
                    if (exp_b.size() == 0 || exp_b[0].d != d) fail($sformatf("b_unexpected_d%0d", d));
                    else begin
                        be = exp_b.pop_front();
                        chk($sformatf("bresp_d%0d", d), bresp_v[d], be.resp);
                        model_pass[d] = model_pass[d] | be.pass;
                    end
                end
                chk($sformatf("tests_passed_d%0d", d), tp_v[d], model_pass[d]);
                if (cv_v[d]) begin
                    cons_count[d]++;
                    last_cons[d] = cd_v[d];
                    if (exp_c.size() == 0 || exp_c[0].d != d) fail($sformatf("console_unexpected_d%0d", d));
                    else begin
                        ce = exp_c.pop_front();
                        chk($sformatf("console_data_d%0d", d), cd_v[d], ce.v);
                    end
                end
                if (r_hold[d]) chk($sformatf("rdata_stable_d%0d", d), rdata_v[d], r_prev[d]);
                if (rvalid_v[d] && rready[d]) begin
                    r_cnt[d]++;
                    last_rdata[d] = rdata_v[d];
                    last_rresp[d] = rresp_v[d];
                    if (exp_r.size() == 0 || exp_r[0].d != d) fail($sformatf("r_unexpected_d%0d", d));
                    else begin
                        re = exp_r.pop_front();
                        chk($sformatf("rdata_d%0d", d), rdata_v[d], re.data);
                        chk($sformatf("rresp_d%0d", d), rresp_v[d], re.resp);
                    end
                end
                r_hold[d] = rvalid_v[d] && !rready[d];
                r_prev[d] = rdata_v[d];
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_write(input int d, input logic [31:0] a, input logic [63:0] dat,
                            input logic [7:0] st, input int w_lead);
        bit aw_done = 0, w_done = 0, hs_aw, hs_w;
        int tgt = b_cnt[d] + 1;
        int cyc = 0;
        exp_b.push_back(model_write(d, a, dat, st));
        awaddr = a; wdata = dat; wstrb = st;
        while (b_cnt[d] < tgt && cyc < 300) begin
            wvalid[d]  = !w_done;
            awvalid[d] = !aw_done && (cyc >= w_lead);
            @(negedge clk);
            hs_aw = awvalid[d] && awready_v[d];
            hs_w  = wvalid[d] && wready_v[d];
            tick();
            aw_done = aw_done | hs_aw;
            w_done  = w_done | hs_w;
            cyc++;
        end
        awvalid[d] = 1'b0;
        wvalid[d]  = 1'b0;
        if (b_cnt[d] < tgt) fail($sformatf("write_timeout_d%0d", d));
    endtask

    task automatic do_read(input int d, input logic [31:0] a);
        int tgt = r_cnt[d] + 1;
        int cyc = 0;
        bit hs;
        araddr = a; rready[d] = 1'b1; arvalid[d] = 1'b1;
        while (arvalid[d] && cyc < 300) begin
            @(negedge clk);
            hs = arvalid[d] && arready_v[d];
            if (hs) exp_r.push_back(model_read(d, a));
            tick();
            if (hs) arvalid[d] = 1'b0;
            cyc++;
        end
        while (r_cnt[d] < tgt && cyc < 300) begin
            tick();
            cyc++;
        end
        arvalid[d] = 1'b0;
        if (r_cnt[d] < tgt) fail($sformatf("read_timeout_d%0d", d));
    endtask

    task automatic burst_test(input int d);
        int  wb = d ? 8 : 4;
        int  issued = 0, acc_pre = 0;
        int  base = r_cnt[d];
        bit  hs;
        time t_first = 0, t_last = 0;
        rready[d] = 1'b0;
        for (int c = 0; c < 400 && r_cnt[d] < base + 5; c++) begin
            if (c == 80) rready[d] = 1'b1;
            arvalid[d] = (issued < 5);
            araddr = 32'h200 + 32'(issued * wb);
            @(negedge clk);
            hs = arvalid[d] && arready_v[d];
            if (hs) exp_r.push_back(model_read(d, araddr));
            tick();
            if (hs) begin
                issued++;
                if (c < 80) acc_pre++;
            end
            if (t_first == 0 && r_cnt[d] == base + 1) t_first = $time;
            if (r_cnt[d] == base + 5) t_last = $time;
        end
        arvalid[d] = 1'b0;
        chk($sformatf("t5_ar_accepted_before_rready_d%0d", d), 64'(acc_pre), 64'd4);
        chk($sformatf("t5_beats_d%0d", d), 64'(r_cnt[d] - base), 64'd5);
        if (d == 0) chk("t5_one_beat_per_cycle", 64'((t_last - t_first) / 10), 64'd4);
    endtask

    task automatic reset_checks(input int d, input string tag);
        chk($sformatf("%s_flags_d%0d", tag, d),
            {awready_v[d], wready_v[d], arready_v[d], bvalid_v[d], rvalid_v[d], cv_v[d], tp_v[d]}, 64'd0);
        chk($sformatf("%s_rdata_d%0d", tag, d), rdata_v[d], 64'd0);
        chk($sformatf("%s_resp_d%0d", tag, d), {bresp_v[d], rresp_v[d]}, 64'd0);
        chk($sformatf("%s_console_data_d%0d", tag, d), cd_v[d], 64'd0);
    endtask

    task automatic run_suite(input int d);
        int wb = d ? 8 : 4;
        logic [7:0] full = d ? 8'hFF : 8'h0F;
        do_write(d, 32'h100, 64'h0000_0000_DEAD_BEEF, full, 0);
        chk("t1_bresp", last_bresp[d], 64'd0);
        do_read(d, 32'h100);
        chk("t1_rdata", last_rdata[d], 64'hDEAD_BEEF);
        chk("t1_rresp", last_rresp[d], 64'd0);
        do_read(d, 32'h103);
        chk("t1_low_bits_ignored", last_rdata[d], 64'hDEAD_BEEF);
        do_write(d, 32'h100, 64'hAA, 8'h01, 0);
        do_read(d, 32'h100);
        chk("t2_rdata", last_rdata[d], 64'hDEAD_BEAA);
        do_write(d, CONSOLE, 64'h41, 8'h01, 3);
        repeat (3) tick();
        chk("t3_console_pulses", 64'(cons_count[d]), 64'd1);
        chk("t3_console_byte", last_cons[d], 64'h41);
        do_write(d, PASSA, 64'd5, full, 0);
        tick();
        chk("t4_wrong_value", tp_v[d], 64'd0);
        do_write(d, PASSA, 64'(PASSV), full, 0);
        tick();
        chk("t4_pass_set", tp_v[d], 64'd1);
        do_write(d, PASSA, 64'd5, full, 0);
        tick();
        chk("t4_pass_sticky", tp_v[d], 64'd1);
        for (int i = 0; i < 5; i++)
            do_write(d, 32'h200 + 32'(i * wb), {32'hA5A5_0000 + 32'(i), 32'h1111_0000 + 32'(i)}, full, 0);
        burst_test(d);
        chk("t5_last_beat", last_rdata[d] & 64'hFFFF_FFFF, 64'h1111_0004);
        do_write(d, 32'h0002_0000, 64'h1234_5678, full, 0);
        chk("t6_bresp", last_bresp[d], 64'd2);
        do_read(d, 32'h0002_0000);
        chk("t6_rresp", last_rresp[d], 64'd2);
        chk("t6_rdata", last_rdata[d], 64'd0);
        do_read(d, CONSOLE);
        chk("mmio_read_resp", last_rresp[d], 64'd0);
        chk("mmio_read_data", last_rdata[d], 64'd0);
        do_read(d, 32'h100);
        chk("t6_sram_untouched", last_rdata[d], 64'hDEAD_BEAA);
    endtask

    initial begin
        awvalid = '0; wvalid = '0; arvalid = '0;
        bready = 2'b11; rready = 2'b11;
        awaddr = '0; araddr = '0; wdata = '0; wstrb = '0;
        model_pass[0] = 1'b0; model_pass[1] = 1'b0;
        for (int d = 0; d < 2; d++) begin
            b_cnt[d] = 0; r_cnt[d] = 0; cons_count[d] = 0;
            last_rdata[d] = '0; last_rresp[d] = '0; last_bresp[d] = '0; last_cons[d] = '0;
            r_hold[d] = 1'b0; r_prev[d] = '0;
        end
        repeat (3) @(posedge clk);
        @(negedge clk);
        for (int d = 0; d < 2; d++) reset_checks(d, "init");
        tick();
        reset = 1'b0;
        tick();

        for (int d = 0; d < 2; d++) run_suite(d);

        // Reset while the 64-bit instance holds a read beat and a queued request
        rready[1] = 1'b0;
        for (int i = 0; i < 2; i++) begin
            araddr = 32'h200 + 32'(i * 8);
            arvalid[1] = 1'b1;
            for (int c = 0; c < 100 && arvalid[1]; c++) begin
                @(negedge clk);
                if (arvalid[1] && arready_v[1]) begin
                    exp_r.push_back(model_read(1, araddr));
                    tick();
                    arvalid[1] = 1'b0;
                end else begin
                    tick();
                end
            end
            arvalid[1] = 1'b0;
        end
        repeat (30) tick();
        chk("pre_reset_rvalid", rvalid_v[1], 64'd1);
        reset = 1'b1;
        exp_r.delete(); exp_b.delete(); exp_c.delete();
        model_pass[0] = 1'b0; model_pass[1] = 1'b0;
        @(negedge clk);
        for (int d = 0; d < 2; d++) reset_checks(d, "midrst");
        tick();
        reset = 1'b0;
        rready = 2'b11;
        repeat (2) tick();
        for (int d = 0; d < 2; d++) begin
            chk("post_reset_tests_passed", tp_v[d], 64'd0);
            do_read(d, 32'h100);
            chk("post_reset_sram_kept", last_rdata[d], 64'hDEAD_BEAA);
        end
        repeat (3) tick();
        chk("exp_r_drained", 64'(exp_r.size()), 64'd0);
        chk("exp_b_drained", 64'(exp_b.size()), 64'd0);
        chk("exp_console_drained", 64'(exp_c.size()), 64'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
